// File: rtl/fxp_mul_pipe.sv
// Two-stage pipelined signed fixed-point multiplier with round/shift, output saturation and a
// saturating count of clamped results. Valid/ready on both sides, single global stall enable.
module fxp_mul_pipe #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned RND   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_p,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_cnt_clr
);

    localparam int unsigned PW = 2 * IN_W;
    localparam int unsigned RW = PW + 1;

    localparam logic signed [RW-1:0] RndAdd =
        (RND != 0 && FRAC > 0) ? (RW'(1) << (FRAC - 1)) : '0;
    localparam logic signed [RW-1:0] MaxV = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] MinV = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic                    adv;
    logic                    s1_v_q;
    logic signed [PW-1:0]    s1_p_q;
    logic signed [PW-1:0]    s1_p_d;
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    b_ext;
    logic signed [RW-1:0]    sum;
    logic signed [RW-1:0]    r;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_p_q;
    logic [OUT_W-1:0]        out_p_d;
    logic                    out_sat_q;
    logic                    out_sat_d;
    logic [CNT_W-1:0]        sat_cnt_q;
    logic [CNT_W-1:0]        sat_cnt_d;

    // Whole pipe moves together; an empty output slot lets bubbles collapse.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign a_ext  = {{IN_W{in_a[IN_W-1]}}, in_a};
    assign b_ext  = {{IN_W{in_b[IN_W-1]}}, in_b};
    assign s1_p_d = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s1_p_q <= '0;
        end else if (adv) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_p_q <= s1_p_d;
            end
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping at the most positive product.
    always_comb begin
        sum       = {s1_p_q[PW-1], s1_p_q} + RndAdd;
        r         = sum >>> FRAC;
        out_p_d   = r[OUT_W-1:0];
        out_sat_d = 1'b0;
        if (r > MaxV) begin
            out_p_d   = {1'b0, {(OUT_W - 1){1'b1}}};
            out_sat_d = 1'b1;
        end else if (r < MinV) begin
            out_p_d   = {1'b1, {(OUT_W - 1){1'b0}}};
            out_sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s1_v_q;
            if (s1_v_q) begin
                out_p_q   <= out_p_d;
                out_sat_q <= out_sat_d;
            end
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Bench for fxp_mul_pipe: a rounding (default) and a truncating, 4-bit-counter instance share
// stimulus; an arithmetic model with an in-order queue checks both every cycle.
module tb_fxp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic        out_ready;
    logic        sat_cnt_clr;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [11:0] out_p0, out_p1;
    logic        out_sat0, out_sat1;
    logic [15:0] sat_cnt0;
    logic [3:0]  sat_cnt1;

    int n_chk = 0;
    int n_fail = 0;

    int qa[$];
    int qb[$];
    int pushed = 0;
    int popped = 0;
    int mcnt0 = 0;
    int mcnt1 = 0;

    always #5 clk = ~clk;

    fxp_mul_pipe #(.IN_W(12), .FRAC(8), .OUT_W(12), .RND(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
        .out_p(out_p0), .out_sat(out_sat0), .sat_cnt(sat_cnt0), .sat_cnt_clr(sat_cnt_clr)
    );

    fxp_mul_pipe #(.IN_W(12), .FRAC(8), .OUT_W(12), .RND(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
        .out_p(out_p1), .out_sat(out_sat1), .sat_cnt(sat_cnt1), .sat_cnt_clr(sat_cnt_clr)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Exact product, optional half-LSB add, floor division by 2^8, clamp to 12-bit signed.
    task automatic model(input int a, input int b, input bit rnd, output int p, output bit sat);
        longint prod;
        longint r;
        prod = longint'(a) * longint'(b);
        if (rnd) prod = prod + 128;
        r = prod >>> 8;
        sat = 1'b0;
        if (r > 2047) begin
            r = 2047;
            sat = 1'b1;
        end else if (r < -2048) begin
            r = -2048;
            sat = 1'b1;
        end
        p = int'(r);
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int  ep0, ep1;
        bit  es0, es1;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid0, 0);
            chk("rst_out_valid_trunc", out_valid1, 0);
            chk("rst_sat_cnt", sat_cnt0, 0);
            qa.delete();
            qb.delete();
            mcnt0 = 0;
            mcnt1 = 0;
        end else begin
            chk("valid_agree", out_valid1, out_valid0);
            chk("in_ready", in_ready0, (!out_valid0 || out_ready) ? 1 : 0);
            chk("sat_cnt", sat_cnt0, mcnt0);
            chk("sat_cnt_trunc", sat_cnt1, mcnt1);
            if (out_valid0) begin
                if (qa.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    model(qa[0], qb[0], 1'b1, ep0, es0);
                    model(qa[0], qb[0], 1'b0, ep1, es1);
                    chk("out_p_rnd", $signed(out_p0), ep0);
                    chk("out_sat_rnd", out_sat0, es0);
                    chk("out_p_trunc", $signed(out_p1), ep1);
                    chk("out_sat_trunc", out_sat1, es1);
                    if (sat_cnt_clr) begin
                        mcnt0 = 0;
                        mcnt1 = 0;
                    end else if (out_ready) begin
                        if (es0 && mcnt0 < 65535) mcnt0++;
                        if (es1 && mcnt1 < 15) mcnt1++;
                    end
                    if (out_ready) begin
                        void'(qa.pop_front());
                        void'(qb.pop_front());
                        popped++;
                    end
                end
            end else if (sat_cnt_clr) begin
                mcnt0 = 0;
                mcnt1 = 0;
            end
            if (in_valid && in_ready0) begin
                qa.push_back(int'($signed(in_a)));
                qb.push_back(int'($signed(in_b)));
                pushed++;
            end
        end
    end

    // Send one pair with out_ready=1; returns one step after the result becomes valid.
    task automatic send1(input int a, input int b);
        bit seen;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a = a[11:0];
        in_b = b[11:0];
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid0) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) chk("result_timeout", 0, 1);
    endtask

    int bp_a[8] = '{100, -300, 2047, -2048, 256, -1, 1000, 16};
    int bp_b[8] = '{200, 50, 2047, 1, -256, -1, -1000, 8};

    initial begin
        int idx;
        bit hs;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        sat_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid0, 0);
        chk("reset_out_p", out_p0, 0);
        chk("reset_out_sat", out_sat0, 0);
        chk("reset_sat_cnt", sat_cnt0, 0);
        chk("reset_in_ready", in_ready0, 1);
        rst_n = 1'b1;

        // Basic product, two-cycle latency.
        send1(12'h180, 12'h240);
        chk("t1_out_p", out_p0, 12'h360);
        chk("t1_out_sat", out_sat0, 0);

        // Negative clamp, counter bumps on the handshake.
        send1(-1422, 1138);
        chk("t2_out_p", out_p0, 12'h800);
        chk("t2_out_sat", out_sat0, 1);
        @(posedge clk); #1;
        chk("t2_sat_cnt", sat_cnt0, 1);

        // Rounding versus floor.
        send1(16, 8);
        chk("t3_rnd_pos", out_p0, 1);
        chk("t3_trunc_pos", out_p1, 0);
        send1(-16, 8);
        chk("t3_rnd_neg", out_p0, 0);
        chk("t3_trunc_neg", $signed(out_p1), -1);

        // Positive clamps.
        send1(12'h7FF, 12'h7FF);
        chk("t4_max_p", out_p0, 12'h7FF);
        chk("t4_max_sat", out_sat0, 1);
        send1(-2048, -2048);
        chk("t4_min_sq_p", out_p0, 12'h7FF);
        chk("t4_min_sq_sat", out_sat0, 1);
        @(posedge clk); #1;

        // Back-to-back stream under random backpressure.
        idx = 0;
        in_valid = 1'b1;
        in_a = bp_a[0][11:0];
        in_b = bp_b[0][11:0];
        out_ready = 1'($urandom_range(0, 1));
        for (int c = 0; c < 200 && idx < 8; c++) begin
            @(negedge clk);
            hs = in_ready0;
            if (out_valid0 && !out_ready) chk("t5_stall_in_ready", in_ready0, 0);
            @(posedge clk); #1;
            if (hs) idx++;
            if (idx >= 8) begin
                in_valid = 1'b0;
            end else begin
                in_a = bp_a[idx][11:0];
                in_b = bp_b[idx][11:0];
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        chk("t5_all_accepted", idx, 8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_drained", qa.size(), 0);
        chk("t5_in_eq_out", popped, pushed);

        // 4-bit counter on the truncating instance saturates at 15.
        for (int k = 0; k < 16; k++) send1(12'h7FF, 12'h7FF);
        @(posedge clk); #1;
        chk("t6_cnt_hold", sat_cnt1, 15);

        // Clear on the same cycle as a saturation event.
        send1(12'h7FF, 12'h7FF);
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        chk("t6_clr_wins", sat_cnt0, 0);
        chk("t6_clr_wins_trunc", sat_cnt1, 0);

        // Reset with two items in flight.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a = 12'h7FF;
        in_b = 12'h7FF;
        @(posedge clk); #1;
        in_a = 12'h100;
        in_b = 12'h100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t6_pre_rst_valid", out_valid0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid0, 0);
        chk("t6_async_sat", out_sat0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("t6_nothing_after_rst", out_valid0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
